// File: rtl/uspispy_logger_pkg.sv
// Shared types and constants for the SPI command logger: FSM states,
// record-length constants and small arithmetic helpers.
package uspispy_logger_pkg;

    // Width of the data-length field carried in every record.
    localparam int LEN_BITS  = 16;
    localparam int LEN_BYTES = LEN_BITS / 8;

    // Saturation value of the dropped-record counter.
    localparam logic [7:0] DROP_MAX = 8'hFF;

    // Capture FSM states. CMD is part of the capture group but is never
    // entered: the command byte is latched on the IDLE -> ADDR transition.
    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        COMMIT
    } state_t;

    // Record size in bytes: command, address bytes, then the length field.
    function automatic int rec_bytes(input int addr_bytes);
        return 1 + addr_bytes + LEN_BYTES;
    endfunction

    // Increment that sticks at DROP_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == DROP_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/uspispy_logger_if.sv
// Bundle of the SPI byte stream, UART byte handshake and drop status.
// master = the environment (SPI synchroniser + UART), slave = the logger.
interface uspispy_logger_if;
    logic       spi_cs;
    logic       spi_byte_strobe;
    logic       spi_start_strobe;
    logic [7:0] spi_byte;
    logic [7:0] uart_tx;
    logic       uart_tx_strobe;
    logic       uart_tx_ready;
    logic [7:0] dropped_count;
    logic       overflow;

    modport master (
        output spi_cs, spi_byte_strobe, spi_start_strobe, spi_byte, uart_tx_ready,
        input  uart_tx, uart_tx_strobe, dropped_count, overflow
    );

    modport slave (
        input  spi_cs, spi_byte_strobe, spi_start_strobe, spi_byte, uart_tx_ready,
        output uart_tx, uart_tx_strobe, dropped_count, overflow
    );
endinterface

// File: rtl/uspispy_logger_byte_fifo.sv
// Byte FIFO with extra-bit pointers: wr == rd means empty, pointers equal
// except for the top bit means full. A push is accepted while full only
// when a pop happens in the same cycle, so occupancy stays unchanged.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free_count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      used;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign used       = wr_ptr - rd_ptr;
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign free_count = (AW + 1)'(DEPTH) - used;
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    assign pop_data   = mem[rd_ptr[AW-1:0]];

    // Pointer update; both pointers wrap naturally through the extra bit.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone define which entries are valid.
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uspispy_logger.sv
// SPI command logger: captures command byte, address and data length of
// each SPI transaction and queues a fixed-size record for a UART. Records
// enter the FIFO whole or not at all; lost records are counted.
module uspispy_logger
    import uspispy_logger_pkg::*;
#(
    parameter int ADDR_BYTES = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_WIDTH  = LEN_BITS
) (
    input logic             clk,
    input logic             reset,
    uspispy_logger_if.slave bus
);
    localparam int REC_BYTES = rec_bytes(ADDR_BYTES);
    localparam int FREE_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FREE_W-1:0] REC_SPACE = FREE_W'(REC_BYTES);

    state_t                  state;
    logic [7:0]              cmd;
    logic [ADDR_BYTES*8-1:0] addr;
    logic [LEN_WIDTH-1:0]    len;
    logic [1:0]              addr_idx;
    logic [2:0]              rec_idx;
    logic [7:0]              dropped_count;
    logic                    overflow;

    logic [REC_BYTES*8-1:0]  rec_bits;
    logic                    start_byte;
    logic                    record_fits;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [7:0]              push_data;
    logic [7:0]              pop_data;
    logic [FREE_W-1:0]       free_count;

    assign start_byte  = bus.spi_byte_strobe && bus.spi_start_strobe;
    // Space is reserved for the whole record before COMMIT starts, so COMMIT
    // never stalls and the FIFO never holds a partial record.
    assign record_fits = (free_count >= REC_SPACE);

    // Capture / commit FSM with drop accounting.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cmd           <= '0;
            addr          <= '0;
            len           <= '0;
            addr_idx      <= '0;
            rec_idx       <= '0;
            dropped_count <= '0;
            overflow      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_byte) begin
                        cmd      <= bus.spi_byte;
                        addr     <= '0;
                        len      <= '0;
                        addr_idx <= '0;
                        state    <= ADDR;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (start_byte) begin
                        // A new transaction abandons the open one.
                        dropped_count <= sat_inc8(dropped_count);
                        overflow      <= 1'b1;
                        cmd           <= bus.spi_byte;
                        addr          <= '0;
                        len           <= '0;
                        addr_idx      <= '0;
                        state         <= ADDR;
                    end else if (bus.spi_cs) begin
                        rec_idx <= '0;
                        if (record_fits) begin
                            state <= COMMIT;
                        end else begin
                            dropped_count <= sat_inc8(dropped_count);
                            overflow      <= 1'b1;
                            state         <= IDLE;
                        end
                    end else if (bus.spi_byte_strobe) begin
                        if (state == DATA) begin
                            if (len != '1) len <= len + LEN_WIDTH'(1);
                        end else begin
                            // Place by index so a short address stays MSB-aligned.
                            addr[(ADDR_BYTES - 1 - int'(addr_idx)) * 8 +: 8] <= bus.spi_byte;
                            addr_idx <= addr_idx + 2'd1;
                            if (addr_idx == 2'(ADDR_BYTES - 1)) state <= DATA;
                        end
                    end
                end
                COMMIT: begin
                    rec_idx <= rec_idx + 3'd1;
                    if (rec_idx == 3'(REC_BYTES - 1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Record layout, first byte sent first: cmd, addr MSB..LSB, len MSB, len LSB.
    assign rec_bits  = {cmd, addr, len};
    assign push_data = rec_bits[(REC_BYTES - 1 - int'(rec_idx)) * 8 +: 8];
    assign fifo_push = (state == COMMIT) && (!fifo_full || fifo_pop);

    // UART side pops the head byte in the same cycle it is presented.
    assign fifo_pop           = bus.uart_tx_ready && !fifo_empty;
    assign bus.uart_tx_strobe = fifo_pop;
    assign bus.uart_tx        = fifo_pop ? pop_data : 8'h00;
    assign bus.dropped_count  = dropped_count;
    assign bus.overflow       = overflow;

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_data  (push_data),
        .pop        (fifo_pop),
        .pop_data   (pop_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .free_count (free_count)
    );

endmodule

// File: tb/tb_uspispy_logger.sv
// Bench for uspispy_logger: two instances (3- and 4-byte address) share one
// SPI/UART stimulus stream and are checked every cycle against a queue-based
// record model, plus literal record expectations for the directed cases.
module tb_uspispy_logger;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs, bs, ss, rdy;
    logic [7:0] sb;

    always #5 clk = ~clk;

    uspispy_logger_if bus3 ();
    uspispy_logger_if bus4 ();

    assign bus3.spi_cs = cs;  assign bus3.spi_byte_strobe = bs;  assign bus3.spi_start_strobe = ss;
    assign bus3.spi_byte = sb; assign bus3.uart_tx_ready = rdy;
    assign bus4.spi_cs = cs;  assign bus4.spi_byte_strobe = bs;  assign bus4.spi_start_strobe = ss;
    assign bus4.spi_byte = sb; assign bus4.uart_tx_ready = rdy;

    uspispy_logger #(.ADDR_BYTES(3), .FIFO_DEPTH(DEPTH)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
    uspispy_logger #(.ADDR_BYTES(4), .FIFO_DEPTH(DEPTH)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    logic       act_stb [2];
    logic [7:0] act_tx  [2];
    logic [7:0] act_drop[2];
    logic       act_ovf [2];
    assign act_stb[0] = bus3.uart_tx_strobe; assign act_stb[1] = bus4.uart_tx_strobe;
    assign act_tx[0]  = bus3.uart_tx;        assign act_tx[1]  = bus4.uart_tx;
    assign act_drop[0] = bus3.dropped_count; assign act_drop[1] = bus4.dropped_count;
    assign act_ovf[0] = bus3.overflow;       assign act_ovf[1] = bus4.overflow;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit rand_rdy = 1'b0;

    // Behavioural model: open capture, pending record bytes, FIFO contents.
    int           ab [2] = '{3, 4};
    byte unsigned fq [2][$];
    byte unsigned cq [2][$];
    byte unsigned rx [2][$];
    bit           open_m [2];
    int           nrx    [2];
    byte unsigned cmd_m  [2];
    byte unsigned addr_m [2][4];
    int           len_m  [2];
    int           drop_m [2];
    bit           ovf_m  [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_open(input int d);
        open_m[d] = 1'b1;
        nrx[d]    = 1;
        cmd_m[d]  = sb;
        len_m[d]  = 0;
        for (int i = 0; i < 4; i++) addr_m[d][i] = 8'h00;
    endtask

    task automatic m_drop(input int d);
        if (drop_m[d] < 255) drop_m[d]++;
        ovf_m[d] = 1'b1;
    endtask

    task automatic m_step(input int d);
        int rec;
        int free;
        rec = 1 + ab[d] + 2;
        if (reset === 1'b0) begin
            fq[d].delete();
            cq[d].delete();
            open_m[d] = 1'b0;
            drop_m[d] = 0;
            ovf_m[d]  = 1'b0;
            return;
        end
        free = DEPTH - fq[d].size();
        if (rdy && fq[d].size() > 0) void'(fq[d].pop_front());
        if (cq[d].size() > 0) begin
            fq[d].push_back(cq[d].pop_front());
        end else if (open_m[d]) begin
            if (bs && ss) begin
                m_drop(d);
                m_open(d);
            end else if (cs) begin
                open_m[d] = 1'b0;
                if (free >= rec) begin
                    cq[d].push_back(cmd_m[d]);
                    for (int i = 0; i < ab[d]; i++) cq[d].push_back(addr_m[d][i]);
                    cq[d].push_back(8'(len_m[d] >> 8));
                    cq[d].push_back(8'(len_m[d] & 255));
                end else begin
                    m_drop(d);
                end
            end else if (bs) begin
                if (nrx[d] < 1 + ab[d]) begin
                    addr_m[d][nrx[d] - 1] = sb;
                    nrx[d]++;
                end else if (len_m[d] < 65535) begin
                    len_m[d]++;
                end
            end
        end else if (bs && ss) begin
            m_open(d);
        end
    endtask

    function automatic bit pending();
        return fq[0].size() > 0 || fq[1].size() > 0 || cq[0].size() > 0 ||
               cq[1].size() > 0 || open_m[0] || open_m[1];
    endfunction

    // Model advances on the same edge the DUTs sample their inputs.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) m_step(d);
    end

    // Mid-cycle compare of every output against the model; logs emitted bytes.
    always @(negedge clk) begin
        bit es;
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                es = rdy && fq[d].size() > 0;
                check($sformatf("a%0d_strobe", ab[d]), act_stb[d], es);
                if (es) check($sformatf("a%0d_tx", ab[d]), act_tx[d], fq[d][0]);
                check($sformatf("a%0d_dropped", ab[d]), act_drop[d], drop_m[d]);
                check($sformatf("a%0d_overflow", ab[d]), act_ovf[d], ovf_m[d]);
                if (act_stb[d] === 1'b1) rx[d].push_back(act_tx[d]);
            end
        end
    end

    // Random UART back-pressure when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit start);
        bs = 1'b1;
        ss = start;
        sb = b;
        tick();
        bs = 1'b0;
        ss = 1'b0;
    endtask

    // Sends n bytes from v (first byte in the top occupied position); rel > 0
    // releases CS for rel cycles afterwards, rel == 0 leaves CS asserted.
    task automatic spi_txn(input logic [63:0] v, input int n, input int gap_max, input int rel);
        cs = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_byte(v[8 * (n - 1 - i) +: 8], i == 0);
            repeat ($urandom_range(0, gap_max)) tick();
        end
        if (rel > 0) begin
            cs = 1'b1;
            repeat (rel) tick();
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        tick();
        while (pending() && n < 300) begin
            tick();
            n++;
        end
        check({name, "_drain_timeout"}, 32'(pending()), 32'd0);
        tick();
    endtask

    task automatic check_rx(input string name, input int d, input logic [127:0] v, input int n);
        check({name, "_count"}, rx[d].size(), n);
        for (int i = 0; i < n && i < rx[d].size(); i++)
            check($sformatf("%s_b%0d", name, i), rx[d][i], v[8 * (n - 1 - i) +: 8]);
    endtask

    task automatic clear_rx();
        rx[0].delete();
        rx[1].delete();
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; cs = 1'b1; bs = 1'b0; ss = 1'b0; sb = 8'h00; rdy = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        check("reset_strobe3", bus3.uart_tx_strobe, 0);
        check("reset_tx3", bus3.uart_tx, 0);
        check("reset_drop3", bus3.dropped_count, 0);
        check("reset_ovf3", bus3.overflow, 0);
        check("reset_strobe4", bus4.uart_tx_strobe, 0);
        check("reset_drop4", bus4.dropped_count, 0);
        check("reset_ovf4", bus4.overflow, 0);
        reset = 1'b1;
        tick();
        rdy = 1'b1;

        // READ with address and four data bytes.
        clear_rx();
        spi_txn(64'h03123456D0D1D2D3, 8, 0, 12);
        wait_drain("read");
        check_rx("read_a3", 0, 128'h031234560004, 6);
        check_rx("read_a4", 1, 128'h03123456D00003, 7);

        // Four-byte address, no data.
        clear_rx();
        spi_txn(64'h13AABBCCDD, 5, 1, 12);
        wait_drain("addr4");
        check_rx("addr4_a3", 0, 128'h13AABBCC0001, 6);
        check_rx("addr4_a4", 1, 128'h13AABBCCDD0000, 7);

        // Command byte alone: address zero-filled.
        clear_rx();
        spi_txn(64'h9F, 1, 0, 12);
        wait_drain("rdid");
        check_rx("rdid_a3", 0, 128'h9F0000000000, 6);
        check_rx("rdid_a4", 1, 128'h9F000000000000, 7);

        // UART stalled: two records fit, the third is dropped.
        rdy = 1'b0;
        clear_rx();
        spi_txn(64'h031234561122, 6, 0, 12);
        spi_txn(64'h0B00001033, 5, 0, 12);
        spi_txn(64'h02ABCDEF44, 5, 0, 12);
        check("full_drop3", bus3.dropped_count, 1);
        check("full_ovf3", bus3.overflow, 1);
        check("full_drop4", bus4.dropped_count, 1);
        check("full_ovf4", bus4.overflow, 1);
        rdy = 1'b1;
        wait_drain("full");
        check_rx("full_a3", 0, 128'h031234560002_0B0000100001, 12);
        check_rx("full_a4", 1, 128'h03123456110001_0B000010330000, 14);

        // Length saturation.
        clear_rx();
        cs = 1'b0;
        send_byte(8'h0B, 1'b1);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        bs = 1'b1;
        repeat (70000) begin
            sb = 8'($urandom);
            tick();
        end
        bs = 1'b0;
        cs = 1'b1;
        wait_drain("long");
        check_rx("long_a3", 0, 128'h0B010203FFFF, 6);

        // Random transactions, abandons, stray bytes and back-pressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 150; t++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                cs = 1'b0;
                repeat (3) send_byte(8'($urandom), 1'b0);
            end else begin
                spi_txn({$urandom, $urandom}, $urandom_range(1, 8), 2,
                        (kind < 3) ? 0 : $urandom_range(1, 12));
            end
        end
        rand_rdy = 1'b0;
        rdy = 1'b1;
        cs  = 1'b1;
        wait_drain("random");

        // Reset while COMMIT has written two bytes.
        rdy = 1'b0;
        cs  = 1'b0;
        send_byte(8'h9F, 1'b1);
        cs = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rdy = 1'b1;
        clear_rx();
        repeat (10) tick();
        check("rst_commit_rx3", rx[0].size(), 0);
        check("rst_commit_rx4", rx[1].size(), 0);
        check("rst_commit_drop3", bus3.dropped_count, 0);
        check("rst_commit_ovf3", bus3.overflow, 0);
        check("rst_commit_strobe3", bus3.uart_tx_strobe, 0);

        // Bytes without a start strobe are ignored.
        cs = 1'b0;
        repeat (5) send_byte(8'($urandom), 1'b0);
        cs = 1'b1;
        repeat (10) tick();
        check("no_start_rx3", rx[0].size(), 0);
        check("no_start_rx4", rx[1].size(), 0);

        // Back-to-back start bytes: 259 abandons saturate the counter.
        cs = 1'b0;
        repeat (260) send_byte(8'($urandom), 1'b1);
        cs = 1'b1;
        wait_drain("sat");
        check("sat_drop3", bus3.dropped_count, 255);
        check("sat_ovf3", bus3.overflow, 1);
        check("sat_drop4", bus4.dropped_count, 255);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uspispy_logger.md
USPISPY_LOGGER -- requirements
Module: uspispy_logger

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide ADDR_BYTES, default 3, giving the number of address bytes captured after the command byte; legal values are 3 or 4.
REQ-002 SHALL provide FIFO_DEPTH, default 16, giving the output FIFO depth in bytes; the value is a power of 2 and at least 2*REC_BYTES.
REQ-003 SHALL provide LEN_WIDTH, default 16, giving the data-length counter width; the value is fixed at 16 for record format.
REQ-004 SHALL use the derived constant REC_BYTES = 1 + ADDR_BYTES + 2.

Ports (name, direction, width, meaning):
REQ-005 SHALL have clk, input, 1: the single clock.
REQ-006 SHALL have reset, input, 1: the reset, which is synchronous and active-low.
REQ-007 SHALL have spi_cs, input, 1: SPI !CS, already synchronised to clk, active-low.
REQ-008 SHALL have spi_byte_strobe, input, 1: one-cycle pulse marking spi_byte as valid.
REQ-009 SHALL have spi_start_strobe, input, 1: qualifies spi_byte_strobe as the first byte after CS assert.
REQ-010 SHALL have spi_byte, input, 8: the received SPI byte.
REQ-011 SHALL have uart_tx, output, 8: the record byte to transmit.
REQ-012 SHALL have uart_tx_strobe, output, 1: one-cycle pulse meaning uart_tx is valid.
REQ-013 SHALL have uart_tx_ready, input, 1: the UART accepts a byte this cycle.
REQ-014 SHALL have dropped_count, output, 8: saturating count of records lost.
REQ-015 SHALL have overflow, output, 1: sticky flag, set on the first dropped record.

Function
REQ-016 SHALL implement the states IDLE, CMD, ADDR, DATA and COMMIT.
REQ-017 SHALL, in IDLE, on spi_byte_strobe with spi_start_strobe: latch cmd=spi_byte, clear addr and len, clear addr_idx, and go to ADDR.
REQ-018 SHALL, in ADDR, on each spi_byte_strobe, shift spi_byte into addr MSB-first; after ADDR_BYTES bytes it goes to DATA.
REQ-019 SHALL, in DATA, increment len on each spi_byte_strobe, saturating at 0xFFFF.
REQ-020 SHALL treat spi_start_strobe in CMD, ADDR or DATA as abandoning the open capture: dropped_count increments, overflow sets, and a new capture starts with this byte.
REQ-021 SHALL, on spi_cs high while in CMD, ADDR or DATA: if FIFO free space >= REC_BYTES, go to COMMIT; otherwise drop the record (dropped_count+1, overflow=1) and go to IDLE.
REQ-022 SHALL zero-fill the low unreceived address bytes of a short command (CS released during ADDR); the received bytes stay MSB-aligned.
REQ-023 SHALL, in COMMIT, write one byte per cycle in the order cmd, addr MSB..LSB, len[15:8], len[7:0], then return to IDLE after REC_BYTES cycles.
REQ-024 SHALL ignore spi_byte_strobe during COMMIT and not count it.
REQ-025 SHALL never write a partial record, so the FIFO always holds whole records.
REQ-026 SHALL, when the FIFO is non-empty and uart_tx_ready=1, assert uart_tx_strobe for one cycle with uart_tx = head byte, and pop that byte in the same cycle.
REQ-027 SHALL have a minimum latency of 1 cycle from a FIFO write to the corresponding uart_tx_strobe.
REQ-028 SHALL handle a simultaneous FIFO write and pop in one cycle with the occupancy unchanged, including when the FIFO is full.
REQ-029 SHALL let read and write pointers wrap modulo FIFO_DEPTH, using an extra pointer bit for full/empty detection.
REQ-030 SHALL saturate dropped_count at 255; overflow is cleared only by reset.

Reset
REQ-031 SHALL, while reset=0 at a clk edge: state=IDLE, FIFO empty, uart_tx=0, uart_tx_strobe=0, dropped_count=0, overflow=0, cmd/addr/len=0.
REQ-032 SHALL discard any open capture or partial COMMIT on reset mid-operation, with no record emitted.
REQ-033 SHALL, after reset is released, keep ignoring SPI bytes until the next spi_start_strobe.

Structure
REQ-034 SHALL place the state enumeration and the REC_BYTES/length-width constants in the shared uspispy package.
REQ-035 SHALL implement the FIFO as one sub-module, byte_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, free-count).
REQ-036 SHALL take its byte stream from qspi_sync; it does not drive the SPI data pins.

Verification
REQ-037 SHALL cover a READ: 0x03 0x12 0x34 0x56 plus 4 data bytes, then CS high -> UART bytes 03 12 34 56 00 04.
REQ-038 SHALL cover ADDR_BYTES=4, 0x13 0xAA 0xBB 0xCC 0xDD plus 0 data bytes -> 13 AA BB CC DD 00 00.
REQ-039 SHALL cover RDID 0x9F alone, then CS high -> 9F 00 00 00 00 00 (ADDR_BYTES=3).
REQ-040 SHALL cover uart_tx_ready held 0 while 3 records arrive with FIFO_DEPTH=16 -> 2 stored, 3rd dropped, dropped_count=1, overflow=1; ready=1 then yields 12 bytes in order.
REQ-041 SHALL cover 70000 data bytes in one transaction -> len field FF FF.
REQ-042 SHALL cover reset=0 asserted during COMMIT after 2 bytes written -> FIFO empty, no uart_tx_strobe, counters 0.
